// File: rtl/interlock_input_conditioner_pkg.sv
// Shared constants for the RPSC interlock input conditioner: default sizing,
// field channel assignments and the default fault-active mask.
package rpsc_cond_pkg;

    localparam int N_CH_DEFAULT        = 42;
    localparam int SYNC_STAGES_DEFAULT = 2;
    localparam int DEB_CYCLES_DEFAULT  = 16;

    localparam int CH_AIR_GRID     = 0;
    localparam int CH_AIR_ANODE    = 1;
    localparam int CH_WATER_AN     = 2;
    localparam int CH_WATER_GRID   = 3;
    localparam int CH_DOOR_PAMP    = 4;
    localparam int CH_DOOR_DRIVER  = 5;
    localparam int CH_PS_FAULT_HV  = 6;
    localparam int CH_PS_FAULT_FIL = 7;
    localparam int CH_STATUS_RF_ON = 40;
    localparam int CH_STATUS_LOCAL = 41;

    // The two top channels are plain status indications, never faults.
    localparam logic [N_CH_DEFAULT-1:0] FAULT_ACT_DEFAULT =
        ~((N_CH_DEFAULT'(1) << CH_STATUS_RF_ON) | (N_CH_DEFAULT'(1) << CH_STATUS_LOCAL));

endpackage

// File: rtl/interlock_input_conditioner_if.sv
// Field-side and core-side signal bundle of the interlock input conditioner.
interface interlock_input_conditioner_if
    import rpsc_cond_pkg::*;
#(
    parameter int N_CH  = N_CH_DEFAULT,
    parameter int IDX_W = $clog2(N_CH)
);
    logic [N_CH-1:0]  i_raw;
    logic [N_CH-1:0]  i_fault_act;
    logic             i_clear;
    logic [N_CH-1:0]  o_clean;
    logic [N_CH-1:0]  o_edge;
    logic [N_CH-1:0]  o_fault_latched;
    logic             o_any_fault;
    logic             o_first_valid;
    logic [IDX_W-1:0] o_first_idx;
    logic [31:0]      o_first_time;

    modport master (
        output i_raw, i_fault_act, i_clear,
        input  o_clean, o_edge, o_fault_latched, o_any_fault,
               o_first_valid, o_first_idx, o_first_time
    );

    modport slave (
        input  i_raw, i_fault_act, i_clear,
        output o_clean, o_edge, o_fault_latched, o_any_fault,
               o_first_valid, o_first_idx, o_first_time
    );
endinterface

// File: rtl/interlock_input_conditioner_debounce.sv
// One field input: multi-flop synchroniser followed by a stable-count debouncer
// that emits a one-cycle pulse whenever the accepted level changes.
module debounce_channel #(
    parameter  int SYNC_STAGES = 2,
    parameter  int DEB_CYCLES  = 16,
    localparam int CNT_W       = $clog2(DEB_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic clean,
    output logic edge_pulse
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   sync_lvl;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // Counter only runs while the synced level disagrees with the accepted one,
    // so it restarts on any bounce and stops at CNT_LAST.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q     <= '0;
            cnt        <= '0;
            clean      <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], raw};
            edge_pulse <= 1'b0;
            if (sync_lvl == clean) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                clean      <= sync_lvl;
                cnt        <= '0;
                edge_pulse <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/interlock_input_conditioner.sv
// Interlock input conditioner: per-channel debounce, sticky fault latches and
// first-fault record. FIRST_FAULT_TIMESTAMP_EN adds a cycle stamp to the record.
module interlock_input_conditioner
    import rpsc_cond_pkg::*;
#(
    parameter  int N_CH        = N_CH_DEFAULT,
    parameter  int SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter  int DEB_CYCLES  = DEB_CYCLES_DEFAULT,
    localparam int IDX_W       = $clog2(N_CH)
) (
    input logic                            clk,
    input logic                            reset,
    interlock_input_conditioner_if.slave   bus
);
    logic [N_CH-1:0]  clean;
    logic [N_CH-1:0]  edge_vec;
    logic [N_CH-1:0]  fcond;
    logic [N_CH-1:0]  latch_q;
    logic [N_CH-1:0]  latch_d;
    logic [N_CH-1:0]  new_set;
    logic             any_q;
    logic             first_valid_q;
    logic [IDX_W-1:0] first_idx_q;
    logic             first_hit;
    logic [IDX_W-1:0] first_sel;
    logic             first_release;
    logic             capture;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_CYCLES  (DEB_CYCLES)
        ) u_deb (
            .clk        (clk),
            .reset      (reset),
            .raw        (bus.i_raw[k]),
            .clean      (clean[k]),
            .edge_pulse (edge_vec[k])
        );
    end

    // A clear only empties latches whose fault has gone away, so set wins.
    assign fcond   = clean & bus.i_fault_act;
    assign latch_d = fcond | (bus.i_clear ? '0 : latch_q);
    assign new_set = latch_d & ~latch_q;

    always_comb begin
        first_hit = 1'b0;
        first_sel = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (new_set[k]) begin
                first_hit = 1'b1;
                first_sel = IDX_W'(k);
            end
        end
    end

    // Only fresh 0->1 transitions re-arm the record, never old latches.
    assign first_release = first_valid_q & bus.i_clear & ~fcond[first_idx_q];
    assign capture       = first_hit & (~first_valid_q | first_release);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            latch_q       <= '0;
            any_q         <= 1'b0;
            first_valid_q <= 1'b0;
            first_idx_q   <= '0;
        end else begin
            latch_q <= latch_d;
            any_q   <= |latch_q;
            if (capture) begin
                first_valid_q <= 1'b1;
                first_idx_q   <= first_sel;
            end else if (first_release) begin
                first_valid_q <= 1'b0;
            end
        end
    end

`ifdef FIRST_FAULT_TIMESTAMP_EN
    logic [31:0] cycle_cnt;
    logic [31:0] first_time_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt    <= '0;
            first_time_q <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (capture) begin
                first_time_q <= cycle_cnt;
            end else if (first_release) begin
                first_time_q <= '0;
            end
        end
    end

    assign bus.o_first_time = first_time_q;
`else
    assign bus.o_first_time = '0;
`endif

    assign bus.o_clean         = clean;
    assign bus.o_edge          = edge_vec;
    assign bus.o_fault_latched = latch_q;
    assign bus.o_any_fault     = any_q;
    assign bus.o_first_valid   = first_valid_q;
    assign bus.o_first_idx     = first_idx_q;
endmodule

// File: tb/tb_interlock_input_conditioner.sv
// Scoreboard bench for interlock_input_conditioner: directed field-input steps
// queue hand-computed expectations that a negedge monitor retires.
module tb_interlock_input_conditioner;
    import rpsc_cond_pkg::*;

    localparam int N_CH        = N_CH_DEFAULT;
    localparam int IDX_W       = $clog2(N_CH);
    localparam int SYNC_STAGES = 2;
    localparam int DEB_CYCLES  = 16;
    localparam int LAT         = SYNC_STAGES + DEB_CYCLES;

    typedef enum int {
        K_CLEAN, K_LATCH, K_ANY, K_FVALID, K_FIDX, K_FTIME
    } kind_t;

    typedef struct {
        int          cyc;
        kind_t       kind;
        int          ch;
        logic [63:0] exp;
    } chk_t;

    typedef struct {
        int              cyc;
        logic [N_CH-1:0] vec;
    } edge_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   rel_cyc = 0;
    chk_t  chk_q[$];
    edge_t edge_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    interlock_input_conditioner_if #(.N_CH(N_CH), .IDX_W(IDX_W)) bus ();

    interlock_input_conditioner #(
        .N_CH        (N_CH),
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_CYCLES  (DEB_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [N_CH-1:0] bitv(int ch);
        return N_CH'(1) << ch;
    endfunction

    // Cycle stamp the record should carry when captured at tb cycle cap_cyc.
    function automatic logic [63:0] ftime_exp(int cap_cyc);
`ifdef FIRST_FAULT_TIMESTAMP_EN
        return 64'(32'(cap_cyc - rel_cyc - 1));
`else
        return 64'(cap_cyc * 0);
`endif
    endfunction

    function automatic logic [63:0] sample(kind_t k, int ch);
        case (k)
            K_CLEAN:  return 64'(bus.o_clean[ch]);
            K_LATCH:  return 64'(bus.o_fault_latched[ch]);
            K_ANY:    return 64'(bus.o_any_fault);
            K_FVALID: return 64'(bus.o_first_valid);
            K_FIDX:   return 64'(bus.o_first_idx);
            K_FTIME:  return 64'(bus.o_first_time);
            default:  return 64'hDEAD;
        endcase
    endfunction

    task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic expect_at(int dc, kind_t k, int ch, logic [63:0] v);
        chk_t c;
        int   pos;
        c.cyc  = cyc + dc;
        c.kind = k;
        c.ch   = ch;
        c.exp  = v;
        pos = chk_q.size();
        while (pos > 0 && chk_q[pos-1].cyc > c.cyc) pos--;
        chk_q.insert(pos, c);
    endtask

    task automatic expect_edge(int dc, logic [N_CH-1:0] v);
        edge_t e;
        int    pos;
        e.cyc = cyc + dc;
        e.vec = v;
        pos = edge_q.size();
        while (pos > 0 && edge_q[pos-1].cyc > e.cyc) pos--;
        edge_q.insert(pos, e);
    endtask

    task automatic applyStimulus(int ch, logic v);
        bus.i_raw[ch] = v;
    endtask

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard: level checks retire on their cycle; every o_edge pulse the
    // DUT presents must match the next queued edge in vector and cycle.
    always @(negedge clk) begin : monitor
        chk_t  c;
        edge_t e;
        while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
            c = chk_q.pop_front();
            if (c.cyc < cyc)
                checkOutput("stale_check_cycle", 64'(cyc), 64'(c.cyc));
            else
                checkOutput($sformatf("%s[%0d]", c.kind.name(), c.ch), sample(c.kind, c.ch), c.exp);
        end
        while (edge_q.size() > 0 && edge_q[0].cyc < cyc) begin
            e = edge_q.pop_front();
            checkOutput("edge_missed_cycle", 64'(cyc), 64'(e.cyc));
        end
        if (bus.o_edge != '0) begin
            if (edge_q.size() == 0) begin
                checkOutput("unexpected_edge", 64'(bus.o_edge), 64'(0));
            end else begin
                e = edge_q.pop_front();
                checkOutput("edge_vec", 64'(bus.o_edge), 64'(e.vec));
                checkOutput("edge_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Reset must clear outputs asynchronously, before any clock edge.
    always @(negedge reset) begin
        #1;
        checkOutput("rst_clean", 64'(bus.o_clean), 64'(0));
        checkOutput("rst_edge", 64'(bus.o_edge), 64'(0));
        checkOutput("rst_latched", 64'(bus.o_fault_latched), 64'(0));
        checkOutput("rst_any", 64'(bus.o_any_fault), 64'(0));
        checkOutput("rst_first_valid", 64'(bus.o_first_valid), 64'(0));
        checkOutput("rst_first_idx", 64'(bus.o_first_idx), 64'(0));
        checkOutput("rst_first_time", 64'(bus.o_first_time), 64'(0));
    end

    task automatic pulse_clear();
        bus.i_clear = 1'b1;
        @(negedge clk);
        bus.i_clear = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        bus.i_raw       = '0;
        bus.i_fault_act = FAULT_ACT_DEFAULT & ~bitv(10);
        bus.i_clear     = 1'b0;
        #2 reset = 1'b0;
        step(3);
        reset   = 1'b1;
        rel_cyc = cyc;

        // Steady step on channel 3 and its first-fault capture.
        step(2);
        applyStimulus(CH_WATER_GRID, 1'b1);
        expect_at(LAT - 1, K_CLEAN, 3, 0);
        expect_at(LAT,     K_CLEAN, 3, 1);
        expect_edge(LAT, bitv(3));
        expect_at(LAT,     K_LATCH, 3, 0);
        expect_at(LAT + 1, K_LATCH, 3, 1);
        expect_at(LAT + 1, K_ANY, 0, 0);
        expect_at(LAT + 2, K_ANY, 0, 1);
        expect_at(LAT + 1, K_FVALID, 0, 1);
        expect_at(LAT + 1, K_FIDX, 0, 3);
        expect_at(LAT + 1, K_FTIME, 0, ftime_exp(cyc + LAT + 1));
        step(LAT + 4);

        // Release channel 3 and clear once its fault condition is gone.
        applyStimulus(CH_WATER_GRID, 1'b0);
        expect_edge(LAT, bitv(3));
        expect_at(LAT, K_CLEAN, 3, 0);
        expect_at(LAT, K_LATCH, 3, 1);
        step(LAT + 2);
        expect_at(1, K_LATCH, 3, 0);
        expect_at(1, K_FVALID, 0, 0);
        expect_at(1, K_FTIME, 0, 0);
        expect_at(2, K_ANY, 0, 0);
        pulse_clear();
        step(3);

        // 15-cycle glitch on 5 is rejected; 16-cycle pulse on non-fault 10 passes.
        applyStimulus(CH_DOOR_DRIVER, 1'b1);
        applyStimulus(10, 1'b1);
        expect_at(LAT - 1, K_CLEAN, 10, 0);
        expect_at(LAT,     K_CLEAN, 10, 1);
        expect_edge(LAT, bitv(10));
        expect_at(LAT,     K_CLEAN, 5, 0);
        expect_at(LAT + 3, K_LATCH, 10, 0);
        expect_at(LAT + 3, K_FVALID, 0, 0);
        expect_at(LAT + 5, K_CLEAN, 5, 0);
        expect_at(LAT + 5, K_LATCH, 5, 0);
        expect_at(LAT + 15, K_CLEAN, 10, 1);
        expect_at(LAT + 16, K_CLEAN, 10, 0);
        expect_edge(LAT + 16, bitv(10));
        step(15);
        applyStimulus(CH_DOOR_DRIVER, 1'b0);
        step(1);
        applyStimulus(10, 1'b0);
        step(LAT + 4);

        // Simultaneous faults on 7 and 2: lowest index is recorded.
        applyStimulus(CH_PS_FAULT_FIL, 1'b1);
        applyStimulus(CH_WATER_AN, 1'b1);
        expect_edge(LAT, bitv(2) | bitv(7));
        expect_at(LAT + 1, K_LATCH, 2, 1);
        expect_at(LAT + 1, K_LATCH, 7, 1);
        expect_at(LAT + 1, K_FVALID, 0, 1);
        expect_at(LAT + 1, K_FIDX, 0, 2);
        expect_at(LAT + 1, K_FTIME, 0, ftime_exp(cyc + LAT + 1));
        begin : phase_active_clear
            logic [63:0] t_first;
            t_first = ftime_exp(cyc + LAT + 1);
            step(LAT + 4);
            expect_at(1, K_LATCH, 2, 1);
            expect_at(1, K_LATCH, 7, 1);
            expect_at(1, K_FVALID, 0, 1);
            expect_at(1, K_FIDX, 0, 2);
            expect_at(1, K_FTIME, 0, t_first);
            pulse_clear();
        end
        step(1);
        applyStimulus(CH_WATER_AN, 1'b0);
        expect_edge(LAT, bitv(2));
        expect_at(LAT, K_CLEAN, 2, 0);
        step(LAT + 2);
        expect_at(1, K_LATCH, 2, 0);
        expect_at(1, K_LATCH, 7, 1);
        expect_at(1, K_FVALID, 0, 0);
        expect_at(1, K_FTIME, 0, 0);
        expect_at(3, K_ANY, 0, 1);
        expect_at(6, K_FVALID, 0, 0);
        pulse_clear();
        step(6);

        // A newly set latch re-arms the record.
        applyStimulus(CH_DOOR_PAMP, 1'b1);
        expect_edge(LAT, bitv(4));
        expect_at(LAT + 1, K_LATCH, 4, 1);
        expect_at(LAT + 1, K_FVALID, 0, 1);
        expect_at(LAT + 1, K_FIDX, 0, 4);
        expect_at(LAT + 1, K_FTIME, 0, ftime_exp(cyc + LAT + 1));
        step(LAT + 4);

        // Reset in the middle of a debounce count with latches set.
        applyStimulus(9, 1'b1);
        step(6);
        @(posedge clk);
        #2;
        reset = 1'b0;
        applyStimulus(CH_DOOR_PAMP, 1'b0);
        applyStimulus(CH_PS_FAULT_FIL, 1'b0);
        step(3);
        reset   = 1'b1;
        rel_cyc = cyc;
        expect_at(1, K_FVALID, 0, 0);
        expect_at(1, K_LATCH, 7, 0);
        expect_at(LAT - 1, K_CLEAN, 9, 0);
        expect_at(LAT,     K_CLEAN, 9, 1);
        expect_edge(LAT, bitv(9));
        expect_at(LAT + 1, K_LATCH, 9, 1);
        expect_at(LAT + 1, K_FVALID, 0, 1);
        expect_at(LAT + 1, K_FIDX, 0, 9);
        expect_at(LAT + 1, K_FTIME, 0, ftime_exp(cyc + LAT + 1));
        step(LAT + 4);

        // Fault captured 100 cycles after a fresh reset release.
        @(posedge clk);
        #2;
        reset = 1'b0;
        applyStimulus(9, 1'b0);
        step(2);
        reset   = 1'b1;
        rel_cyc = cyc;
        step(100 - LAT - 1);
        applyStimulus(12, 1'b1);
        expect_edge(LAT, bitv(12));
        expect_at(LAT + 1, K_FVALID, 0, 1);
        expect_at(LAT + 1, K_FIDX, 0, 12);
        expect_at(LAT + 1, K_FTIME, 0, ftime_exp(cyc + LAT + 1));
        step(LAT + 4);

        step(3);
        checkOutput("pending_checks", 64'(chk_q.size()), 64'(0));
        checkOutput("pending_edges", 64'(edge_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/interlock_input_conditioner.md
Name: interlock_input_conditioner

Overview:
- Front-end stage that feeds the RPSC interlock core.
- Per channel, it synchronises and debounces the raw field interlock and status inputs (air, water, door, PS faults, etc.).
- Latches every asserted fault and records which channel faulted first for operator diagnostics.
- Outputs drive the core's interlock inputs and the panel first-fault indicator.

Parameters:
- N_CH, 42, number of conditioned input channels.
- SYNC_STAGES, 2, synchroniser flop depth (minimum 2).
- DEB_CYCLES, 16, consecutive stable cycles required to accept a new level (minimum 1).
- CNT_W, $clog2(DEB_CYCLES+1), debounce counter width (derived, do not override).
- IDX_W, $clog2(N_CH), first-fault index width (derived).

Ports:
- clk  in  1  system clock, shared with the interlock core.
- reset  in  1  asynchronous, active-low reset.
- i_raw  in  N_CH  raw, asynchronous field inputs.
- i_fault_act  in  N_CH  static per-channel flag; 1 marks a channel whose clean level 1 is a fault.
- i_clear  in  1  synchronous one-cycle fault-clear request (operator reset).
- o_clean  out  N_CH  debounced levels.
- o_edge  out  N_CH  one-cycle pulse on any o_clean change.
- o_fault_latched  out  N_CH  sticky fault flags.
- o_any_fault  out  1  OR of o_fault_latched.
- o_first_valid  out  1  first-fault record valid.
- o_first_idx  out  IDX_W  index of the first latched channel.
- o_first_time  out  32  cycle stamp of the first fault (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous): all synchroniser flops, counters, o_clean, o_edge, o_fault_latched, o_any_fault, o_first_valid, o_first_idx and o_first_time clear to 0.
- Synchroniser: i_raw[k] passes through SYNC_STAGES flops to give sync[k].
- Debounce, per channel, counter cnt[k]:
  - sync==o_clean: cnt<=0.
  - sync!=o_clean and cnt<DEB_CYCLES-1: cnt<=cnt+1.
  - sync!=o_clean and cnt==DEB_CYCLES-1: o_clean<=sync, cnt<=0, o_edge=1 for exactly that next cycle.
  - Latency: a raw step held steady appears on o_clean SYNC_STAGES+DEB_CYCLES cycles after the first sampling edge.
  - A glitch shorter than DEB_CYCLES synced cycles never reaches o_clean.
  - The counter saturates by construction and never wraps.
- Fault condition: fcond[k] = o_clean[k] & i_fault_act[k].
  - Latch set: fcond=1 sets o_fault_latched[k] on the next edge.
  - Latch clear: i_clear clears o_fault_latched[k] only when fcond[k]=0 in the same cycle.
  - Set wins over clear: if fcond=1 while i_clear=1, the latch stays 1.
- o_any_fault is registered, one cycle behind o_fault_latched.
- First fault:
  - Capture: when o_first_valid=0 and any latch transitions 0->1, capture the lowest such index into o_first_idx and set o_first_valid.
  - Simultaneous new faults: the lowest index wins.
  - After capture, further faults are ignored until cleared.
  - Clear: i_clear drops o_first_valid only if that channel's latch clears in the same cycle. A still-latched channel that was not first does not re-arm the capture; a newly set latch re-arms it.
- Reset mid-debounce: the counter is discarded and o_clean returns to 0.
- A channel with i_fault_act=0 is debounced only and never latches.

Optional Feature:
- Macro: FIRST_FAULT_TIMESTAMP_EN.
- Defined:
  - Adds a free-running 32-bit cycle counter, cleared by reset and wrapping at 2^32-1 -> 0.
  - Its value is captured into o_first_time in the same cycle as o_first_idx.
  - o_first_time clears when o_first_valid clears.
- Undefined: no counter is built and o_first_time is tied to 0. The port list is identical in both builds.

Decomposition:
- Shared package rpsc_cond_pkg holds:
  - Default N_CH and DEB_CYCLES.
  - localparam channel index constants (e.g. CH_AIR_GRID, CH_WATER_AN, CH_DOOR_PAMP).
  - Default fault-active mask constant FAULT_ACT_DEFAULT.
- Sub-module debounce_channel: one-bit synchroniser + counter + o_clean/o_edge, instanced N_CH times with a generate loop.
- The top level holds the latches, the first-fault priority encoder and the optional timestamp.

Test Plan:
- Steady step: raw[3]=1 held, DEB_CYCLES=16, SYNC_STAGES=2 -> o_clean[3] rises exactly 18 cycles later, with a one-cycle o_edge[3].
- Glitch: raw[5] high for 15 cycles then low -> o_clean[5], o_edge[5] and the latch stay 0 throughout.
- Simultaneous faults: raw[7] and raw[2] rise in the same cycle with fault_act set -> both latches set, o_first_idx=2, o_first_valid=1.
- Clear while active: i_clear pulses while fcond[2]=1 -> latch[2] and o_first_valid stay 1. After raw[2] drops and debounces, a second i_clear -> latch[2]=0 and o_first_valid=0.
- Reset mid-operation: reset low 3 cycles during a count with latches set -> all outputs 0 immediately (asynchronous). After release, a held input needs the full 18 cycles again.
- Timestamp build: with FIRST_FAULT_TIMESTAMP_EN, a fault captured 100 cycles after reset release -> o_first_time=100±sync offset as computed by the model. Without the macro -> o_first_time=0.
